// File: rtl/execute_mc.sv
// rtl/execute_mc.sv - multi-cycle execute unit: ALU, branch/jump, load/store handshake, optional iterative mul/div (EXECUTE_MC_MULDIV_EN)
module execute_mc #(
    parameter int XLEN    = 32,
    parameter int WORD_PC = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            is_jump,
    output logic [XLEN-1:0] jump_dest,
    output logic            illegal,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] STEP = (WORD_PC != 0) ? XLEN'(1) : XLEN'(4);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_BEQ   = 5'd10;
    localparam logic [4:0] OP_BNE   = 5'd11;
    localparam logic [4:0] OP_BLT   = 5'd12;
    localparam logic [4:0] OP_BGE   = 5'd13;
    localparam logic [4:0] OP_BLTU  = 5'd14;
    localparam logic [4:0] OP_BGEU  = 5'd15;
    localparam logic [4:0] OP_JAL   = 5'd16;
    localparam logic [4:0] OP_JALR  = 5'd17;
    localparam logic [4:0] OP_LOAD  = 5'd18;
    localparam logic [4:0] OP_STORE = 5'd19;
    localparam logic [4:0] OP_MUL   = 5'd20;
`ifdef EXECUTE_MC_MULDIV_EN
    localparam logic [4:0] OP_MULH  = 5'd21;
    localparam logic [4:0] OP_MULHU = 5'd22;
    localparam logic [4:0] OP_DIV   = 5'd23;
    localparam logic [4:0] OP_DIVU  = 5'd24;
    localparam logic [4:0] OP_REM   = 5'd25;
    localparam logic [4:0] OP_REMU  = 5'd26;
    localparam logic [4:0] OP_ILL   = 5'd27;
`endif

    typedef enum logic [1:0] {IDLE, MEM, MULDIV, DONE} state_t;
    state_t state_q, state_d;

    logic [4:0]      op_q;
    logic [XLEN-1:0] pc_q, imm_q, rs1_q, rs2_q;
    logic [XLEN-1:0] rd_q, jump_dest_q;
    logic            is_jump_q, illegal_q;

    logic            accept, is_mem_in, illegal_in, alu_jump, taken;
    logic [XLEN-1:0] offset, alu_rd, alu_dest;

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign is_mem_in = (op == OP_LOAD) || (op == OP_STORE);
    assign offset    = (WORD_PC != 0) ? XLEN'($signed(imm) >>> 2) : imm;
`ifdef EXECUTE_MC_MULDIV_EN
    assign illegal_in = (op >= OP_ILL);
`else
    assign illegal_in = (op >= OP_MUL);
`endif

    // Single-cycle result; anything not matched here (illegal, mem, mul/div) yields rd=0, next PC=pc+step.
    always_comb begin
        alu_rd   = '0;
        alu_jump = 1'b0;
        alu_dest = pc + STEP;
        taken    = 1'b0;
        case (op)
            OP_ADD:  alu_rd = rs1 + rs2;
            OP_SUB:  alu_rd = rs1 - rs2;
            OP_AND:  alu_rd = rs1 & rs2;
            OP_OR:   alu_rd = rs1 | rs2;
            OP_XOR:  alu_rd = rs1 ^ rs2;
            OP_SLL:  alu_rd = rs1 << rs2[SW-1:0];
            OP_SRL:  alu_rd = rs1 >> rs2[SW-1:0];
            OP_SRA:  alu_rd = XLEN'($signed(rs1) >>> rs2[SW-1:0]);
            OP_SLT:  alu_rd = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            OP_SLTU: alu_rd = {{(XLEN-1){1'b0}}, rs1 < rs2};
            OP_BEQ:  taken = (rs1 == rs2);
            OP_BNE:  taken = (rs1 != rs2);
            OP_BLT:  taken = ($signed(rs1) < $signed(rs2));
            OP_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            OP_BLTU: taken = (rs1 < rs2);
            OP_BGEU: taken = (rs1 >= rs2);
            OP_JAL: begin
                alu_jump = 1'b1;
                alu_dest = pc + offset;
                alu_rd   = pc + STEP;
            end
            OP_JALR: begin
                alu_jump = 1'b1;
                alu_dest = rs1 + offset;
                alu_rd   = pc + STEP;
            end
            default: ;
        endcase
        if ((op >= OP_BEQ) && (op <= OP_BGEU)) begin
            alu_jump = taken;
            alu_dest = taken ? (pc + offset) : (pc + STEP);
        end
    end

`ifdef EXECUTE_MC_MULDIV_EN
    logic                is_md_in, is_div_in, signed_in, a_neg, b_neg, neg_in;
    logic                div_zero, div_ovf, md_fast, neg_q;
    logic [XLEN-1:0]     a_mag, b_mag, md_fast_rd, md_rd, mcand_q;
    logic [2*XLEN-1:0]   work_q, work_d, prod_neg;
    logic [XLEN:0]       mul_sum, div_diff;
    logic [SW-1:0]       cnt_q;

    // Both engines run on magnitudes; the sign is re-applied once at the end.
    always_comb begin
        is_md_in   = (op >= OP_MUL) && (op <= OP_REMU);
        is_div_in  = (op >= OP_DIV) && (op <= OP_REMU);
        signed_in  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg      = signed_in && rs1[XLEN-1];
        b_neg      = signed_in && rs2[XLEN-1];
        a_mag      = a_neg ? -rs1 : rs1;
        b_mag      = b_neg ? -rs2 : rs2;
        neg_in     = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
        div_zero   = (rs2 == '0);
        div_ovf    = ((op == OP_DIV) || (op == OP_REM)) &&
                     (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        md_fast    = is_div_in && (div_zero || div_ovf);
        md_fast_rd = '0;
        case (op)
            OP_DIV:  md_fast_rd = div_zero ? '1 : rs1;
            OP_DIVU: md_fast_rd = '1;
            OP_REM:  md_fast_rd = div_zero ? rs1 : '0;
            OP_REMU: md_fast_rd = rs1;
            default: ;
        endcase
    end

    // work_q is {acc_hi, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, mcand_q} : '0);
        div_diff = work_q[2*XLEN-1:XLEN-1] - {1'b0, mcand_q};
        if (op_q >= OP_DIV) begin
            if (!div_diff[XLEN])
                work_d = {div_diff[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
            else
                work_d = {work_q[2*XLEN-2:0], 1'b0};
        end else begin
            work_d = {mul_sum, work_q[XLEN-1:1]};
        end
        prod_neg = -work_d;
        md_rd    = '0;
        case (op_q)
            OP_MUL:   md_rd = work_d[XLEN-1:0];
            OP_MULH:  md_rd = neg_q ? prod_neg[2*XLEN-1:XLEN] : work_d[2*XLEN-1:XLEN];
            OP_MULHU: md_rd = work_d[2*XLEN-1:XLEN];
            OP_DIV:   md_rd = neg_q ? -work_d[XLEN-1:0] : work_d[XLEN-1:0];
            OP_DIVU:  md_rd = work_d[XLEN-1:0];
            OP_REM:   md_rd = neg_q ? -work_d[2*XLEN-1:XLEN] : work_d[2*XLEN-1:XLEN];
            OP_REMU:  md_rd = work_d[2*XLEN-1:XLEN];
            default: ;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal_in)     state_d = DONE;
                    else if (is_mem_in) state_d = MEM;
`ifdef EXECUTE_MC_MULDIV_EN
                    else if (is_md_in && !md_fast) state_d = MULDIV;
`endif
                    else                state_d = DONE;
                end
            end
            MEM:     if (mem_ack) state_d = DONE;
`ifdef EXECUTE_MC_MULDIV_EN
            MULDIV:  if (cnt_q == SW'(XLEN-1)) state_d = DONE;
`else
            MULDIV:  state_d = IDLE;
`endif
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_q        <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            is_jump_q   <= 1'b0;
            jump_dest_q <= '0;
            illegal_q   <= 1'b0;
`ifdef EXECUTE_MC_MULDIV_EN
            work_q      <= '0;
            mcand_q     <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q        <= op;
                        pc_q        <= pc;
                        imm_q       <= imm;
                        rs1_q       <= rs1;
                        rs2_q       <= rs2;
                        rd_q        <= alu_rd;
                        is_jump_q   <= alu_jump;
                        jump_dest_q <= alu_dest;
                        illegal_q   <= illegal_in;
`ifdef EXECUTE_MC_MULDIV_EN
                        if (is_md_in) begin
                            if (md_fast) rd_q <= md_fast_rd;
                            work_q  <= {{XLEN{1'b0}}, (is_div_in ? a_mag : b_mag)};
                            mcand_q <= is_div_in ? b_mag : a_mag;
                            neg_q   <= neg_in;
                            cnt_q   <= '0;
                        end
`endif
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        rd_q        <= (op_q == OP_LOAD) ? mem_rdata : '0;
                        jump_dest_q <= pc_q + STEP;
                    end
                end
                MULDIV: begin
`ifdef EXECUTE_MC_MULDIV_EN
                    work_q <= work_d;
                    cnt_q  <= cnt_q + SW'(1);
                    if (cnt_q == SW'(XLEN-1)) begin
                        rd_q        <= md_rd;
                        jump_dest_q <= pc_q + STEP;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state_q == DONE);
    assign rd        = rd_q;
    assign is_jump   = is_jump_q;
    assign jump_dest = jump_dest_q;
    assign illegal   = illegal_q;
    assign mem_req   = (state_q == MEM);
    assign mem_we    = mem_req && (op_q == OP_STORE);
    assign mem_addr  = rs1_q + imm_q;
    assign mem_wdata = rs2_q;

endmodule

// File: tb/tb_execute_mc.sv
// tb/tb_execute_mc.sv - vector table, hand sequences and randomized reference-model checks for execute_mc
module tb_execute_mc;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [31:0] pc = '0, imm = '0, rs1 = '0, rs2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] rd, jump_dest, mem_addr, mem_wdata;
    logic        is_jump, illegal, mem_req, mem_we;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    execute_mc #(.XLEN(32), .WORD_PC(1)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .pc(pc), .imm(imm), .rs1(rs1), .rs2(rs2),
        .out_valid(out_valid), .out_ready(out_ready), .rd(rd),
        .is_jump(is_jump), .jump_dest(jump_dest), .illegal(illegal),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] rd;
        logic        j;
        logic [31:0] dest;
        logic        ill;
        int          lat;
    } res_t;

    typedef struct {
        string       name;
        logic [4:0]  o;
        logic [31:0] p, i, a, b;
        res_t        e;
    } vec_t;

    vec_t vt[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input string n, input logic [4:0] o, input logic [31:0] p, i, a, b,
                        input logic [31:0] erd, input logic ej, input logic [31:0] edest,
                        input logic eill, input int elat);
        vec_t v;
        v.name = n; v.o = o; v.p = p; v.i = i; v.a = a; v.b = b;
        v.e.rd = erd; v.e.j = ej; v.e.dest = edest; v.e.ill = eill; v.e.lat = elat;
        vt.push_back(v);
    endtask

    // Reference behaviour from the instruction rules, with 64-bit arithmetic for mul/div.
    function automatic res_t model(input logic [4:0] o, input logic [31:0] p, i, a, b, rdata,
                                   input int ack_n);
        res_t r;
        logic signed [31:0] sa, sb, off;
        logic        taken, ovf;
        longint      ps;
        logic [63:0] pu;
        sa = a; sb = b;
        off = $signed(i) >>> 2;
        r.rd = '0; r.j = 1'b0; r.dest = p + 32'd1; r.ill = 1'b0; r.lat = 1;
        taken = 1'b0;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ps = 0; pu = '0;
        case (o)
            5'd0:  r.rd = a + b;
            5'd1:  r.rd = a - b;
            5'd2:  r.rd = a & b;
            5'd3:  r.rd = a | b;
            5'd4:  r.rd = a ^ b;
            5'd5:  r.rd = a << b[4:0];
            5'd6:  r.rd = a >> b[4:0];
            5'd7:  r.rd = sa >>> b[4:0];
            5'd8:  r.rd = (sa < sb) ? 32'd1 : 32'd0;
            5'd9:  r.rd = (a < b) ? 32'd1 : 32'd0;
            5'd10: taken = (a == b);
            5'd11: taken = (a != b);
            5'd12: taken = (sa < sb);
            5'd13: taken = (sa >= sb);
            5'd14: taken = (a < b);
            5'd15: taken = (a >= b);
            5'd16: begin r.j = 1'b1; r.dest = p + off; r.rd = p + 32'd1; end
            5'd17: begin r.j = 1'b1; r.dest = a + off; r.rd = p + 32'd1; end
            5'd18: begin r.rd = rdata; r.lat = ack_n + 1; end
            5'd19: r.lat = ack_n + 1;
`ifdef EXECUTE_MC_MULDIV_EN
            5'd20: begin r.rd = a * b; r.lat = 33; end
            5'd21: begin ps = longint'(sa) * longint'(sb); r.rd = ps[63:32]; r.lat = 33; end
            5'd22: begin pu = {32'd0, a} * {32'd0, b}; r.rd = pu[63:32]; r.lat = 33; end
            5'd23: begin
                if (b == 0) r.rd = '1; else if (ovf) r.rd = a; else r.rd = sa / sb;
                r.lat = (b == 0 || ovf) ? 1 : 33;
            end
            5'd24: begin r.rd = (b == 0) ? '1 : a / b; r.lat = (b == 0) ? 1 : 33; end
            5'd25: begin
                if (b == 0) r.rd = a; else if (ovf) r.rd = '0; else r.rd = sa % sb;
                r.lat = (b == 0 || ovf) ? 1 : 33;
            end
            5'd26: begin r.rd = (b == 0) ? a : a % b; r.lat = (b == 0) ? 1 : 33; end
`endif
            default: r.ill = 1'b1;
        endcase
        if (o >= 5'd10 && o <= 5'd15) begin
            r.j = taken;
            r.dest = taken ? p + off : p + 32'd1;
        end
        return r;
    endfunction

    task automatic do_reset();
        rstn = 1'b0; in_valid = 1'b0; mem_ack = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rstn = 1'b1;
    endtask

    task automatic run_op(input string name, input logic [4:0] o, input logic [31:0] p, i, a, b,
                          input logic [31:0] rdata, input int ack_n, input int hold_n,
                          input res_t e);
        int cyc = 0;
        int memcyc = 0;
        bit got = 0;
        logic [31:0] rd_seen;
        op = o; pc = p; imm = i; rs1 = a; rs2 = b;
        in_valid = 1'b1; out_ready = (hold_n == 0); mem_ack = 1'b0;
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        while (!got && cyc < 200) begin
            tick();
            cyc++;
            in_valid = 1'b0;
            mem_ack = 1'b0;
            if (out_valid) begin
                got = 1;
            end else if (mem_req) begin
                memcyc++;
                check({name, "_mem_addr"}, mem_addr, a + i);
                check({name, "_mem_wdata"}, mem_wdata, b);
                check({name, "_mem_we"}, 32'(mem_we), 32'(o == 5'd19));
                check({name, "_busy_ready"}, 32'(in_ready), 32'd0);
                if (memcyc == ack_n) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
        end
        mem_ack = 1'b0;
        check({name, "_latency"}, 32'(cyc), 32'(e.lat));
        if (!got) begin
            do_reset();
            return;
        end
        check({name, "_rd"}, rd, e.rd);
        check({name, "_is_jump"}, 32'(is_jump), 32'(e.j));
        check({name, "_jump_dest"}, jump_dest, e.dest);
        check({name, "_illegal"}, 32'(illegal), 32'(e.ill));
        rd_seen = rd;
        for (int k = 0; k < hold_n; k++) begin
            tick();
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_rd"}, rd, rd_seen);
            check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check({name, "_release_valid"}, 32'(out_valid), 32'd0);
        check({name, "_release_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic reset_mid(input string name, input logic [4:0] o, input logic [31:0] a, b,
                             input int n_wait);
        bit saw = 0;
        op = o; pc = 32'h80; imm = 32'h8; rs1 = a; rs2 = b;
        in_valid = 1'b1; out_ready = 1'b1; mem_ack = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (n_wait) tick();
        check({name, "_busy"}, 32'(in_ready), 32'd0);
        rstn = 1'b0;
        tick();
        check({name, "_rst_valid"}, 32'(out_valid), 32'd0);
        check({name, "_rst_mem_req"}, 32'(mem_req), 32'd0);
        check({name, "_rst_mem_addr"}, mem_addr, 32'd0);
        check({name, "_rst_dest"}, jump_dest, 32'd0);
        rstn = 1'b1;
        check({name, "_rel_ready"}, 32'(in_ready), 32'd1);
        repeat (40) begin
            tick();
            saw |= out_valid;
        end
        check({name, "_never_valid"}, 32'(saw), 32'd0);
    endtask

    initial begin
        res_t e;
        logic [4:0]  ro;
        logic [31:0] rp, ri, ra, rb, rdat;
        int          ack_n;

        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rd", rd, 32'd0);
        check("rst_is_jump", 32'(is_jump), 32'd0);
        check("rst_jump_dest", jump_dest, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rstn = 1'b1;
        check("rst_release_ready", 32'(in_ready), 32'd1);

        addv("add_wrap",  5'd0,  32'h40,  32'h0,        32'hFFFF_FFFF, 32'h2,  32'h1,        1'b0, 32'h41,   1'b0, 1);
        addv("beq_taken", 5'd10, 32'h100, 32'h10,       32'h5,         32'h5,  32'h0,        1'b1, 32'h104,  1'b0, 1);
        addv("beq_not",   5'd10, 32'h100, 32'h10,       32'h5,         32'h6,  32'h0,        1'b0, 32'h101,  1'b0, 1);
        addv("sub_wrap",  5'd1,  32'h0,   32'h0,        32'h0,         32'h1,  32'hFFFF_FFFF, 1'b0, 32'h1,   1'b0, 1);
        addv("sra",       5'd7,  32'h10,  32'h0,        32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 32'h11,  1'b0, 1);
        addv("sll31",     5'd5,  32'h10,  32'h0,        32'h1,         32'h1F, 32'h8000_0000, 1'b0, 32'h11,  1'b0, 1);
        addv("slt",       5'd8,  32'h20,  32'h0,        32'hFFFF_FFFF, 32'h1,  32'h1,        1'b0, 32'h21,   1'b0, 1);
        addv("sltu",      5'd9,  32'h20,  32'h0,        32'hFFFF_FFFF, 32'h1,  32'h0,        1'b0, 32'h21,   1'b0, 1);
        addv("jal_back",  5'd16, 32'h200, 32'hFFFF_FFF0, 32'h0,        32'h0,  32'h201,      1'b1, 32'h1FC,  1'b0, 1);
        addv("jalr",      5'd17, 32'h300, 32'h8,        32'h1000,      32'h0,  32'h301,      1'b1, 32'h1002, 1'b0, 1);
        addv("bltu",      5'd14, 32'h50,  32'h20,       32'h1,         32'hFFFF_FFFF, 32'h0, 1'b1, 32'h58,   1'b0, 1);
        addv("blt",       5'd12, 32'h50,  32'h20,       32'h1,         32'hFFFF_FFFF, 32'h0, 1'b0, 32'h51,   1'b0, 1);
        addv("xor",       5'd4,  32'h0,   32'h0,        32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 32'h1, 1'b0, 1);
        addv("illegal30", 5'd30, 32'h7,   32'h0,        32'h1,         32'h2,  32'h0,        1'b0, 32'h8,    1'b1, 1);
`ifdef EXECUTE_MC_MULDIV_EN
        addv("div_neg",   5'd23, 32'h0,   32'h0,        32'hFFFF_FFF9, 32'h2,  32'hFFFF_FFFD, 1'b0, 32'h1,   1'b0, 33);
        addv("div_zero",  5'd23, 32'h0,   32'h0,        32'h5,         32'h0,  32'hFFFF_FFFF, 1'b0, 32'h1,   1'b0, 1);
        addv("mulhu_max", 5'd22, 32'h0,   32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32'h1, 1'b0, 33);
        addv("rem_ovf",   5'd25, 32'h0,   32'h0,        32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h1,    1'b0, 1);
        addv("mulh_neg",  5'd21, 32'h0,   32'h0,        32'hFFFF_FFFE, 32'h3,  32'hFFFF_FFFF, 1'b0, 32'h1,   1'b0, 33);
        addv("remu",      5'd26, 32'h0,   32'h0,        32'd100,       32'd7,  32'd2,        1'b0, 32'h1,    1'b0, 33);
`else
        addv("div_off",   5'd23, 32'h0,   32'h0,        32'hFFFF_FFF9, 32'h2,  32'h0,        1'b0, 32'h1,    1'b1, 1);
        addv("mul_off",   5'd20, 32'h4,   32'h0,        32'h3,         32'h3,  32'h0,        1'b0, 32'h5,    1'b1, 1);
`endif

        foreach (vt[n])
            run_op(vt[n].name, vt[n].o, vt[n].p, vt[n].i, vt[n].a, vt[n].b, 32'h0, 1, 0, vt[n].e);

        e.rd = 32'hDEAD_BEEF; e.j = 1'b0; e.dest = 32'h61; e.ill = 1'b0; e.lat = 4;
        run_op("load_hold", 5'd18, 32'h60, 32'h4, 32'h20, 32'h55, 32'hDEAD_BEEF, 3, 2, e);
        e.rd = 32'h0; e.j = 1'b0; e.dest = 32'h1; e.ill = 1'b0; e.lat = 2;
        run_op("store", 5'd19, 32'h0, 32'hFFFF_FFFC, 32'h100, 32'hCAFE_F00D, 32'h0, 1, 0, e);

        reset_mid("rst_in_mem", 5'd18, 32'h40, 32'h0, 3);
`ifdef EXECUTE_MC_MULDIV_EN
        reset_mid("rst_in_div", 5'd23, 32'd100, 32'd3, 9);
`endif

        for (int n = 0; n < 60; n++) begin
            ro = 5'($urandom_range(0, 31));
            rp = $urandom; ri = $urandom; ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            rdat = $urandom;
            ack_n = $urandom_range(1, 4);
            e = model(ro, rp, ri, ra, rb, rdat, ack_n);
            run_op($sformatf("rand%0d_op%0d", n, ro), ro, rp, ri, ra, rb, rdat, ack_n,
                   $urandom_range(0, 1), e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
